// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state codes, standard IR opcodes and opcode legality helper
// Contents:
//   TAP_*      : 4-bit TAP controller state codes (all 16 codes defined)
//   OP_*       : standard instruction opcodes, zero-extended to 8 bits
//   is_legal() : looks up an opcode in an implemented-opcode bit mask
package jtag_pkg;

    localparam logic [3:0] TAP_EXIT2_DR   = 4'h0;
    localparam logic [3:0] TAP_EXIT1_DR   = 4'h1;
    localparam logic [3:0] TAP_SHIFT_DR   = 4'h2;
    localparam logic [3:0] TAP_PAUSE_DR   = 4'h3;
    localparam logic [3:0] TAP_SELECT_IR  = 4'h4;
    localparam logic [3:0] TAP_UPDATE_DR  = 4'h5;
    localparam logic [3:0] TAP_CAPTURE_DR = 4'h6;
    localparam logic [3:0] TAP_SELECT_DR  = 4'h7;
    localparam logic [3:0] TAP_EXIT2_IR   = 4'h8;
    localparam logic [3:0] TAP_EXIT1_IR   = 4'h9;
    localparam logic [3:0] TAP_SHIFT_IR   = 4'hA;
    localparam logic [3:0] TAP_PAUSE_IR   = 4'hB;
    localparam logic [3:0] TAP_RTI        = 4'hC;
    localparam logic [3:0] TAP_UPDATE_IR  = 4'hD;
    localparam logic [3:0] TAP_CAPTURE_IR = 4'hE;
    localparam logic [3:0] TAP_TLR        = 4'hF;

    localparam logic [7:0] OP_BYPASS   = 8'h00;
    localparam logic [7:0] OP_SAMPLE   = 8'h01;
    localparam logic [7:0] OP_PRELOAD  = 8'h02;
    localparam logic [7:0] OP_EXTEST   = 8'h03;
    localparam logic [7:0] OP_INTEST   = 8'h04;
    localparam logic [7:0] OP_RUNBIST  = 8'h05;
    localparam logic [7:0] OP_CLAMP    = 8'h06;
    localparam logic [7:0] OP_IDCODE   = 8'h07;
    localparam logic [7:0] OP_USERCODE = 8'h08;
    localparam logic [7:0] OP_HIGHZ    = 8'h09;

    // Opcode and mask are passed at the widest supported size (8-bit IR,
    // 256-entry mask); callers zero-extend their narrower values.
    function automatic logic is_legal(input logic [7:0] op, input logic [255:0] mask);
        return mask[op];
    endfunction

endpackage

// File: rtl/jtag_ir_decode.sv
// rtl/jtag_ir_decode.sv - opcode legality check and DR-select decode
// Ports:
//   op_i         : candidate opcode (shift stage contents)
//   legal_o      : 1 when op_i is an implemented opcode
//   ir_i         : instruction to decode (next-state or current JTAG_IR)
//   sel_bypass_o : ir_i selects the bypass register (BYPASS_OP or all ones)
//   sel_idcode_o : ir_i selects the IDCODE register
module jtag_ir_decode
    import jtag_pkg::*;
#(
    parameter int                       IR_WIDTH    = 4,
    parameter logic [IR_WIDTH-1:0]      BYPASS_OP   = 'h0,
    parameter logic [IR_WIDTH-1:0]      IDCODE_OP   = 'h7,
    parameter logic [2**IR_WIDTH-1:0]   OPCODE_MASK = 'h03FF
) (
    input  logic [IR_WIDTH-1:0] op_i,
    output logic                legal_o,
    input  logic [IR_WIDTH-1:0] ir_i,
    output logic                sel_bypass_o,
    output logic                sel_idcode_o
);

    assign legal_o      = is_legal(8'(op_i), 256'(OPCODE_MASK));
    // All-ones is the mandatory BYPASS encoding regardless of BYPASS_OP.
    assign sel_bypass_o = (ir_i == BYPASS_OP) || (&ir_i);
    assign sel_idcode_o = (ir_i == IDCODE_OP);

endmodule

// File: rtl/jtag_ir_reg.sv
// rtl/jtag_ir_reg.sv - JTAG instruction register with capture, shift and update stages
// Ports:
//   TCK, rst       : test clock, synchronous active-high reset
//   TDI, TDO       : serial in / serial out (shift[0]), TDO_EN high in Shift-IR
//   state          : TAP state code from the TAP controller
//   CAPTURE_STATUS : status bits loaded into shift[IR_WIDTH-1:2] at Capture-IR
//   JTAG_IR        : current instruction
//   IR_UPDATED     : one-cycle pulse when JTAG_IR is loaded
//   IR_REJECTED    : one-cycle pulse when an update is refused or substituted
//   SHIFT_ERR      : sticky short-shift flag, cleared at Capture-IR
//   SEL_BYPASS     : registered BYPASS decode of JTAG_IR
//   SEL_IDCODE     : registered IDCODE decode of JTAG_IR
module jtag_ir_reg
    import jtag_pkg::*;
#(
    parameter int                       IR_WIDTH    = 4,
    parameter logic [IR_WIDTH-1:0]      IDCODE_OP   = 'h7,
    parameter logic [IR_WIDTH-1:0]      BYPASS_OP   = 'h0,
    parameter logic [2**IR_WIDTH-1:0]   OPCODE_MASK = 'h03FF,
    parameter bit                       STRICT_LEN  = 1'b1
) (
    input  logic                TCK,
    input  logic                rst,
    input  logic                TDI,
    input  logic [3:0]          state,
    input  logic [IR_WIDTH-3:0] CAPTURE_STATUS,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [IR_WIDTH-1:0] JTAG_IR,
    output logic                IR_UPDATED,
    output logic                IR_REJECTED,
    output logic                SHIFT_ERR,
    output logic                SEL_BYPASS,
    output logic                SEL_IDCODE
);

    localparam int                  CNT_W     = $clog2(IR_WIDTH + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(IR_WIDTH);
    localparam logic [IR_WIDTH-1:0] SHIFT_RST = IR_WIDTH'(1);
    localparam logic                RST_SEL_BYPASS = (IDCODE_OP == BYPASS_OP) || (&IDCODE_OP);

    logic [IR_WIDTH-1:0] shift_q, shift_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                upd_q, upd_d;
    logic                rej_q, rej_d;
    logic                err_q, err_d;
    logic                sel_byp_q, sel_byp_d;
    logic                sel_id_q, sel_id_d;

    logic [IR_WIDTH-1:0] capture_val;
    logic                op_legal;

    // Bits [1:0] are the fixed 01 pattern, so a board test sees 1 then 0 first.
    generate
        if (IR_WIDTH > 2) begin : g_cap_status
            assign capture_val = {CAPTURE_STATUS, 2'b01};
        end else begin : g_cap_fixed
            assign capture_val = SHIFT_RST;
        end
    endgenerate

    // SEL_* are decoded from ir_d so they change on the same edge as JTAG_IR.
    jtag_ir_decode #(
        .IR_WIDTH    (IR_WIDTH),
        .BYPASS_OP   (BYPASS_OP),
        .IDCODE_OP   (IDCODE_OP),
        .OPCODE_MASK (OPCODE_MASK)
    ) u_decode (
        .op_i         (shift_q),
        .legal_o      (op_legal),
        .ir_i         (ir_d),
        .sel_bypass_o (sel_byp_d),
        .sel_idcode_o (sel_id_d)
    );

    always_comb begin
        shift_d = shift_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        upd_d   = 1'b0;
        rej_d   = 1'b0;
        if (state == TAP_TLR) begin
            // Test-Logic-Reset behaves exactly like rst for every cycle it is held.
            shift_d = SHIFT_RST;
            ir_d    = IDCODE_OP;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state)
                TAP_CAPTURE_IR: begin
                    shift_d = capture_val;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
                TAP_SHIFT_IR: begin
                    shift_d = {TDI, shift_q[IR_WIDTH-1:1]};
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                TAP_UPDATE_IR: begin
                    if (STRICT_LEN && (cnt_q < CNT_MAX)) begin
                        rej_d = 1'b1;
                        err_d = 1'b1;
                    end else if (!op_legal) begin
                        // Unimplemented opcodes fall back to BYPASS so the
                        // scan chain stays one bit long and predictable.
                        ir_d  = BYPASS_OP;
                        rej_d = 1'b1;
                        upd_d = 1'b1;
                    end else begin
                        ir_d  = shift_q;
                        upd_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge TCK) begin
        if (rst) begin
            shift_q   <= SHIFT_RST;
            ir_q      <= IDCODE_OP;
            cnt_q     <= '0;
            upd_q     <= 1'b0;
            rej_q     <= 1'b0;
            err_q     <= 1'b0;
            sel_byp_q <= RST_SEL_BYPASS;
            sel_id_q  <= 1'b1;
        end else begin
            shift_q   <= shift_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            upd_q     <= upd_d;
            rej_q     <= rej_d;
            err_q     <= err_d;
            sel_byp_q <= sel_byp_d;
            sel_id_q  <= sel_id_d;
        end
    end

    assign TDO         = shift_q[0];
    assign TDO_EN      = (state == TAP_SHIFT_IR);
    assign JTAG_IR     = ir_q;
    assign IR_UPDATED  = upd_q;
    assign IR_REJECTED = rej_q;
    assign SHIFT_ERR   = err_q;
    assign SEL_BYPASS  = sel_byp_q;
    assign SEL_IDCODE  = sel_id_q;

endmodule
